// File: rtl/mm_stream_pkg.sv
// Shared types for the MM_ultra operand streamers: beat payload type and sequencer states.
package mm_stream_pkg;

  localparam int A_SIZE     = 16;
  localparam int DATA_WIDTH = 8;
  localparam int BEAT_W     = A_SIZE * DATA_WIDTH;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/mm_skid_fifo2.sv
// Two-entry FIFO carrying a beat payload plus its last flag; push and pop may coincide.
module mm_skid_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_push_last,
  input  logic         i_pop,
  output logic [W-1:0] o_head_data,
  output logic         o_head_last,
  output logic [1:0]   o_count,
  output logic         o_empty
);

  logic [W-1:0] r_data0;
  logic [W-1:0] r_data1;
  logic         r_last0;
  logic         r_last1;
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0  <= '0;
      r_data1  <= '0;
      r_last0  <= 1'b0;
      r_last1  <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) begin
          r_data1 <= i_push_data;
          r_last1 <= i_push_last;
        end else begin
          r_data0 <= i_push_data;
          r_last0 <= i_push_last;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_rd_ptr ? r_data1 : r_data0;
  assign o_head_last = r_rd_ptr ? r_last1 : r_last0;
  assign o_count     = r_count;
  assign o_empty     = (r_count == 2'd0);

endmodule

// File: rtl/mm_tile_streamer.sv
// Streams a contiguous run of BRAM words onto a valid/ready/last link feeding one MM_ultra operand port.
module mm_tile_streamer
  import mm_stream_pkg::*;
#(
  parameter int A_size     = A_SIZE,
  parameter int data_width = DATA_WIDTH,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [LEN_WIDTH-1:0]           beat_count,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic [A_size*data_width-1:0]   mem_rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [A_size*data_width-1:0]   out_data
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_issued;
  logic [LEN_WIDTH-1:0]   r_accepted;
  logic                   r_inflight;
  logic                   r_inflight_last;
  logic [1:0]             w_count;
  logic                   w_empty;
  logic                   w_pop;
  logic [2:0]             w_occ;
  logic                   w_issue_last;
  logic [LEN_WIDTH-1:0]   w_acc_next;

  assign w_pop        = out_valid && out_ready;
  // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
  assign w_occ        = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign mem_rd_en    = (r_state == RUN) && (w_occ < 3'd2) && (r_issued < r_len);
  assign mem_rd_addr  = r_base + ADDR_WIDTH'(r_issued);
  assign w_issue_last = (r_issued == r_len - LEN_WIDTH'(1));
  assign w_acc_next   = r_accepted + LEN_WIDTH'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_base          <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_accepted      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && start) begin
        r_base     <= base_addr;
        r_len      <= beat_count;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (mem_rd_en) r_issued <= r_issued + LEN_WIDTH'(1);
        if (w_pop)     r_accepted <= w_acc_next;
      end
      r_inflight      <= mem_rd_en;
      r_inflight_last <= mem_rd_en && w_issue_last;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = (beat_count == '0) ? FIN : RUN;
      RUN:     if (mem_rd_en && w_issue_last) w_next_state = DRAIN;
      // Leaving on the final handshake edge puts done one cycle after it.
      DRAIN:   if (w_acc_next == r_len) w_next_state = FIN;
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign busy = (r_state == RUN) || (r_state == DRAIN);
  assign done = (r_state == FIN);

  mm_skid_fifo2 #(
    .W(A_size * data_width)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (mem_rd_data),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_head_data (out_data),
    .o_head_last (out_last),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  assign out_valid = !w_empty;

endmodule

// File: tb/tb_mm_tile_streamer.sv
// Randomised bench for mm_tile_streamer against a BRAM image and an index-based stream model.
module tb_mm_tile_streamer;
  import mm_stream_pkg::*;

  localparam int AW    = 12;
  localparam int LW    = 16;
  localparam int DEPTH = 1 << AW;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [LW-1:0]  beat_count;
  logic           busy;
  logic           done;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_rd_addr;
  beat_t          mem_rd_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  beat_t          out_data;

  beat_t mem [0:DEPTH-1];
  int    checks;
  int    errors;

  mm_tile_streamer #(
    .A_size(A_SIZE), .data_width(DATA_WIDTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .beat_count(beat_count), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM: data appears one cycle after the enable.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Runs one transfer, checking every read address, beat, stall hold and the done pulse.
  task automatic run_stream(input int base, input int len, input bit randReady,
                            input int retrigAt, input int abortAt);
    int     idx, rdIdx, k, doneCnt, doneK, lastHsK, firstHsK, firstRdK, firstValK, stallCnt;
    bit     prevStall, prevLast, finished, aborted, retrigDone, expLast, expBusy;
    beat_t  prevData, expData;
    logic [AW-1:0] expAddr;
    idx = 0; rdIdx = 0; doneCnt = 0; doneK = -1; lastHsK = -10; firstHsK = -1;
    firstRdK = -1; firstValK = -1; stallCnt = 0; prevStall = 0; prevLast = 0;
    finished = 0; aborted = 0; retrigDone = 0; prevData = '0;
    @(posedge clk); #1;
    base_addr  = AW'(base);
    beat_count = LW'(len);
    start      = 1'b1;
    out_ready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    for (k = 1; k <= 10000 && !finished; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (retrigAt >= 0 && idx == retrigAt && !retrigDone) begin
        start      = 1'b1;
        base_addr  = AW'(base + 7);
        beat_count = LW'(5);
        retrigDone = 1;
      end
      if (abortAt >= 0 && idx >= abortAt) out_ready = 1'b0;
      else out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      checks++;
      if (dut.u_fifo.r_count > 2'd2) begin
        errors++;
        $display("[TB] FAIL fifo_overflow: count %0d, limit 2", dut.u_fifo.r_count);
      end
      if (mem_rd_en) begin
        if (firstRdK < 0) firstRdK = k;
        expAddr = AW'((base + rdIdx) % DEPTH);
        checks++;
        if (rdIdx >= len || mem_rd_addr !== expAddr) begin
          errors++;
          $display("[TB] FAIL rd_addr: read %0d got addr %0d, want %0d (len %0d)",
                   rdIdx, mem_rd_addr, expAddr, len);
        end
        rdIdx++;
      end
      if (prevStall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prevData || out_last !== prevLast) begin
          errors++;
          $display("[TB] FAIL stall_hold: valid %b last %b data %h, want held last %b data %h",
                   out_valid, out_last, out_data, prevLast, prevData);
        end
      end
      if (out_valid === 1'b1 && firstValK < 0) firstValK = k;
      if (out_valid === 1'b1 && out_ready) begin
        expData = mem[(base + idx) % DEPTH];
        expLast = (idx == len - 1);
        checks++;
        if (idx >= len || out_data !== expData || out_last !== expLast) begin
          errors++;
          $display("[TB] FAIL beat: beat %0d got data %h last %b, want data %h last %b",
                   idx, out_data, out_last, expData, expLast);
        end
        if (firstHsK < 0) firstHsK = k;
        if (expLast) lastHsK = k;
        idx++;
      end
      prevStall = (out_valid === 1'b1) && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
      expBusy = (len > 0) && (doneCnt == 0) && (done !== 1'b1);
      checks++;
      if (busy !== expBusy) begin
        errors++;
        $display("[TB] FAIL busy: cycle %0d got %b, want %b", k, busy, expBusy);
      end
      if (done === 1'b1) begin
        doneCnt++;
        if (doneK < 0) doneK = k;
        checks++;
        if (idx != len || (len > 0 && lastHsK != k - 1) || (len == 0 && k > 2)) begin
          errors++;
          $display("[TB] FAIL done_timing: cycle %0d beats %0d last-handshake cycle %0d, want beats %0d and done next cycle",
                   k, idx, lastHsK, len);
        end
      end
      if (doneK >= 0 && k >= doneK + 8) finished = 1;
      if (abortAt >= 0 && idx >= abortAt) begin
        stallCnt++;
        if (stallCnt >= 4) begin
          aborted = 1;
          break;
        end
      end
    end
    if (!aborted) begin
      checks++;
      if (!finished || doneCnt != 1 || idx != len || rdIdx != len) begin
        errors++;
        $display("[TB] FAIL run_summary: finished %b done pulses %0d beats %0d reads %0d, want 1 pulse, %0d beats/reads",
                 finished, doneCnt, idx, rdIdx, len);
      end
      if (len == 0) begin
        checks++;
        if (firstRdK >= 0 || firstValK >= 0) begin
          errors++;
          $display("[TB] FAIL zero_len_activity: first read cycle %0d first valid cycle %0d, want none",
                   firstRdK, firstValK);
        end
      end else if (!randReady) begin
        checks++;
        if (firstRdK != 1 || firstValK != 3 || lastHsK - firstHsK != len - 1) begin
          errors++;
          $display("[TB] FAIL latency_rate: first read %0d first valid %0d span %0d, want 1, 3, %0d",
                   firstRdK, firstValK, lastHsK - firstHsK, len - 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; beat_count = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== '0 ||
        out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy %b done %b rd_en %b addr %0d valid %b last %b data %h, want all 0",
               busy, done, mem_rd_en, mem_rd_addr, out_valid, out_last, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_throughput();
    $display("[TB] full-rate run of 1200 beats");
    run_stream(0, 1200, 1'b0, -1, -1);
  endtask

  task automatic test_backpressure();
    $display("[TB] 1200 beats with random ready");
    run_stream(0, 1200, 1'b1, -1, -1);
  endtask

  task automatic test_zero_len();
    $display("[TB] zero-length request");
    run_stream(5, 0, 1'b0, -1, -1);
  endtask

  task automatic test_wrap();
    $display("[TB] address wrap from 4094");
    run_stream(4094, 4, 1'b0, -1, -1);
  endtask

  task automatic test_retrigger();
    $display("[TB] start pulsed during a 96-beat run");
    run_stream(300, 96, 1'b1, 10, -1);
  endtask

  task automatic test_reset_mid_run();
    $display("[TB] reset asserted mid-run");
    run_stream(100, 200, 1'b0, -1, 50);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== '0 ||
        out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: busy %b done %b rd_en %b addr %0d valid %b last %b data %h, want all 0",
               busy, done, mem_rd_en, mem_rd_addr, out_valid, out_last, out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_stream(100, 16, 1'b1, -1, -1);
  endtask

  task automatic test_random_runs();
    $display("[TB] random base/length runs");
    for (int r = 0; r < 4; r++) begin
      run_stream(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 1'b1, -1, -1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    test_reset();
    test_throughput();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_retrigger();
    test_reset_mid_run();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
